// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte width, length-prefix address and the FSM state encoding
// used by both prga_enc and rc4_ks_step.
package rc4_pkg;

    localparam int unsigned BYTE_W = 8;

    // Byte 0 of every PT/CT message holds the payload length.
    localparam logic [BYTE_W-1:0] LEN_ADDR = '0;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WR_LEN,
        RD_SI,
        RD_SJ,
        WR_SJ,
        WR_SI,
        RD_PAD,
        WR_CT
    } state_e;

endpackage

// File: rtl/rc4_ks_step.sv
// One RC4 PRGA step on a single-port S memory: read S[i+1], read S[j], swap, then issue the
// pad read at S[si+sj]. The read of S[i+1] happens in the start cycle itself.
module rc4_ks_step
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              start,
    output logic              done,
    output logic [BYTE_W-1:0] s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] i_q, i_d;
    logic [BYTE_W-1:0] j_q, j_d;
    logic [BYTE_W-1:0] si_q, si_d;
    logic [BYTE_W-1:0] sj_q, sj_d;

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        done     = 1'b0;
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;

        if (clr) begin
            i_d = '0;
            j_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    s_addr  = i_q + 8'd1;
                    i_d     = i_q + 8'd1;
                    state_d = RD_SJ;
                end
            end
            RD_SJ: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                s_addr  = j_q + s_rddata;
                state_d = WR_SJ;
            end
            WR_SJ: begin
                sj_d     = s_rddata;
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = WR_SI;
            end
            WR_SI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = RD_PAD;
            end
            RD_PAD: begin
                s_addr  = si_q + sj_q;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

endmodule

// File: rtl/prga_enc.sv
// RC4 encryptor: copies the length byte from PT to CT, then XORs each payload byte with the
// keystream. Define PRGA_ENC_CONT_EN to keep i/j running across messages.
module prga_enc
    import rc4_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          rdy,
    output logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_rddata,
    output logic [DW-1:0] s_wrdata,
    output logic          s_wren,
    output logic [AW-1:0] pt_addr,
    input  logic [DW-1:0] pt_rddata,
    output logic [AW-1:0] ct_addr,
    output logic [DW-1:0] ct_wrdata,
    output logic          ct_wren
);

`ifdef PRGA_ENC_CONT_EN
    localparam bit ClrOnAccept = 1'b0;
`else
    localparam bit ClrOnAccept = 1'b1;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [DW-1:0] len_q, len_d;
    logic          step_clr;
    logic          step_start;
    logic          step_done;

    rc4_ks_step u_ks_step (
        .clk      (clk),
        .rst      (rst),
        .clr      (step_clr),
        .start    (step_start),
        .done     (step_done),
        .s_addr   (s_addr),
        .s_rddata (s_rddata),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren)
    );

    // The keystream step is started in WR_LEN/WR_CT so its S[i+1] read overlaps the CT
    // write; RD_SI is where this FSM waits while the step runs.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        len_d      = len_q;
        rdy        = 1'b0;
        pt_addr    = '0;
        ct_addr    = '0;
        ct_wrdata  = '0;
        ct_wren    = 1'b0;
        step_clr   = 1'b0;
        step_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    k_d      = 8'd1;
                    step_clr = ClrOnAccept;
                    state_d  = RD_LEN;
                end
            end
            RD_LEN: begin
                pt_addr = LEN_ADDR;
                state_d = WR_LEN;
            end
            WR_LEN: begin
                len_d     = pt_rddata;
                ct_addr   = LEN_ADDR;
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                if (pt_rddata == '0) begin
                    state_d = IDLE;
                end else begin
                    step_start = 1'b1;
                    state_d    = RD_SI;
                end
            end
            RD_SI: begin
                if (step_done) begin
                    pt_addr = k_q;
                    state_d = WR_CT;
                end
            end
            WR_CT: begin
                ct_addr   = k_q;
                ct_wrdata = s_rddata ^ pt_rddata;
                ct_wren   = 1'b1;
                if (k_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    k_d        = k_q + 8'd1;
                    step_start = 1'b1;
                    state_d    = RD_SI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_prga_enc.sv
// Bench for prga_enc: behavioural S/PT/CT memories, software RC4 model feeding a CT-write
// scoreboard, plus fixed-value checks for the known identity-S vectors.
module tb_prga_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic [7:0] pt_addr, pt_rddata;
    logic [7:0] ct_addr, ct_wrdata;
    logic       s_wren, ct_wren;

    always #5 clk = ~clk;

    prga_enc #(.DW(8), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    logic [7:0] s_mem   [256];
    logic [7:0] pt_mem  [256];
    logic [7:0] ct_mem  [256];
    bit         ct_valid[256];
    logic [7:0] s_init  [256];
    logic [7:0] pt_init [256];
    logic       load_s  = 1'b0;
    logic       load_pt = 1'b0;
    int         s_wr_cnt = 0;

    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (load_s) begin
            for (int a = 0; a < 256; a++) s_mem[8'(a)] <= s_init[8'(a)];
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_cnt      <= s_wr_cnt + 1;
        end
        if (load_pt) begin
            for (int a = 0; a < 256; a++) begin
                pt_mem[8'(a)]   <= pt_init[8'(a)];
                ct_valid[8'(a)] <= 1'b0;
            end
        end else if (ct_wren) begin
            ct_mem[ct_addr]   <= ct_wrdata;
            ct_valid[ct_addr] <= 1'b1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard entries are {ct_addr, ct_wrdata}.
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        logic [15:0] e;
        if (ct_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ct_unexpected_write", 32'(ct_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("ct_addr", 32'(ct_addr), 32'(e[15:8]));
                check("ct_data", 32'(ct_wrdata), 32'(e[7:0]));
                check("single_write", 32'(s_wren), 32'd0);
            end
        end
    end

    // Software RC4 reference state.
    logic [7:0] sm[256];
    logic [7:0] i_m = 8'd0;
    logic [7:0] j_m = 8'd0;

    task automatic model_byte(output logic [7:0] pad);
        logic [7:0] si, sj, t;
        i_m = i_m + 8'd1;
        si  = sm[i_m];
        j_m = j_m + si;
        sj  = sm[j_m];
        sm[i_m] = sj;
        sm[j_m] = si;
        t   = si + sj;
        pad = sm[t];
    endtask

    task automatic push_expected();
        logic [7:0] len, pad, k;
        len = pt_init[8'd0];
`ifndef PRGA_ENC_CONT_EN
        i_m = 8'd0;
        j_m = 8'd0;
`endif
        exp_q.push_back({8'h00, len});
        for (int n = 1; n <= int'(len); n++) begin
            k = 8'(n);
            model_byte(pad);
            exp_q.push_back({k, pt_init[k] ^ pad});
        end
    endtask

    task automatic load_mems(input bit ls, input bit lp);
        @(negedge clk);
        load_s  = ls;
        load_pt = lp;
        @(negedge clk);
        load_s  = 1'b0;
        load_pt = 1'b0;
        if (ls) for (int a = 0; a < 256; a++) sm[8'(a)] = s_init[8'(a)];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        i_m = 8'd0;
        j_m = 8'd0;
        exp_q.delete();
    endtask

    // Counts the negedges at which rdy is low after the accepting edge.
    task automatic run_msg(input bit hold, input string tag, input int exp_lat);
        int cyc;
        push_expected();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        if (!hold) en = 1'b0;
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        en = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic identity_s();
        for (int a = 0; a < 256; a++) s_init[8'(a)] = 8'(a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] key[5];
        logic [7:0] jj, tmp;
        int         w, mism;

        for (int a = 0; a < 256; a++) pt_init[8'(a)] = 8'h00;
        identity_s();
        load_mems(1'b1, 1'b1);
        do_reset();
        check("rst_rdy", 32'(rdy), 32'd1);
        check("rst_s_wren", 32'(s_wren), 32'd0);
        check("rst_ct_wren", 32'(ct_wren), 32'd0);

        // Identity S, zero payload: CT is the raw keystream.
        pt_init[0] = 8'h03; pt_init[1] = 8'h00; pt_init[2] = 8'h00; pt_init[3] = 8'h00;
        load_mems(1'b1, 1'b1);
        run_msg(1'b0, "t1", 17);
        check("t1_ct0", 32'(ct_mem[0]), 32'h03);
        check("t1_ct1", 32'(ct_mem[1]), 32'h02);
        check("t1_ct2", 32'(ct_mem[2]), 32'h05);
        check("t1_ct3", 32'(ct_mem[3]), 32'h07);
        check("t1_s2", 32'(s_mem[2]), 32'h03);
        check("t1_s3", 32'(s_mem[3]), 32'h05);
        check("t1_s5", 32'(s_mem[5]), 32'h02);

        // Second message on the S left by the first.
        pt_init[0] = 8'h01; pt_init[1] = 8'h00;
        load_mems(1'b0, 1'b1);
        run_msg(1'b0, "t4", 7);
`ifdef PRGA_ENC_CONT_EN
        check("t4_ct1", 32'(ct_mem[1]), 32'h0D);
`else
        check("t4_ct1", 32'(ct_mem[1]), 32'h03);
`endif

        do_reset();
        identity_s();
        pt_init[0] = 8'h03; pt_init[1] = 8'hFF; pt_init[2] = 8'h10; pt_init[3] = 8'hAA;
        load_mems(1'b1, 1'b1);
        run_msg(1'b0, "t2", 17);
        check("t2_ct1", 32'(ct_mem[1]), 32'hFD);
        check("t2_ct2", 32'(ct_mem[2]), 32'h15);
        check("t2_ct3", 32'(ct_mem[3]), 32'hAD);

        // Empty message: only the length byte is written.
        pt_init[0] = 8'h00;
        load_mems(1'b0, 1'b1);
        w = s_wr_cnt;
        run_msg(1'b0, "t3", 2);
        check("t3_no_s_writes", 32'(s_wr_cnt - w), 32'd0);
        check("t3_ct0", 32'(ct_mem[0]), 32'h00);
        check("t3_ct1_unwritten", 32'(ct_valid[1]), 32'd0);

        // Abort during byte 2 of a 3-byte message.
        identity_s();
        pt_init[0] = 8'h03; pt_init[1] = 8'h11; pt_init[2] = 8'h22; pt_init[3] = 8'h33;
        load_mems(1'b1, 1'b1);
        push_expected();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_ct_wren", 32'(ct_wren), 32'd0);
        check("t5_s_wren", 32'(s_wren), 32'd0);
        check("t5_rdy", 32'(rdy), 32'd1);
        rst = 1'b0;
        check("t5_pending", 32'(exp_q.size()), 32'd2);
        check("t5_ct1_written", 32'(ct_valid[1]), 32'd1);
        check("t5_ct2_unwritten", 32'(ct_valid[2]), 32'd0);
        check("t5_ct3_unwritten", 32'(ct_valid[3]), 32'd0);
        exp_q.delete();
        i_m = 8'd0;
        j_m = 8'd0;
        load_mems(1'b1, 1'b1);
        run_msg(1'b0, "t5_restart", 17);

        // Full-length message on a KSA-scheduled S, en held high throughout.
        for (int a = 0; a < 5; a++) key[a] = 8'($urandom);
        identity_s();
        jj = 8'd0;
        for (int a = 0; a < 256; a++) begin
            jj  = jj + s_init[8'(a)] + key[a % 5];
            tmp = s_init[8'(a)];
            s_init[8'(a)] = s_init[jj];
            s_init[jj]    = tmp;
        end
        pt_init[0] = 8'd255;
        for (int a = 1; a < 256; a++) pt_init[8'(a)] = 8'($urandom);
        load_mems(1'b1, 1'b1);
        run_msg(1'b1, "t6", 1277);
        mism = 0;
        for (int a = 0; a < 256; a++) if (s_mem[8'(a)] !== sm[8'(a)]) mism++;
        check("t6_s_final", 32'(mism), 32'd0);
        repeat (4) @(negedge clk);
        check("t6_stays_idle", 32'(rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prga_enc.md
Name: prga_enc

Overview:
- RC4 keystream encryptor. Reads a length-prefixed plaintext message from PT memory, generates the RC4 keystream from an already-scheduled S memory, and writes the length-prefixed ciphertext to CT memory.
- Sits after KSA. It is the transmit-side counterpart of the PRGA decrypt path and uses the same S/PT/CT memory conventions.
- All memories are synchronous, with 1-cycle read latency.

Parameters:
- DW, 8, data/byte width (fixed by RC4; not meant to be overridden)
- AW, 8, memory address width; the maximum message length is 2^AW-1 = 255

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high only in IDLE
- s_addr  out  8  S memory address
- s_rddata  in  8  S read data; holds the word addressed on the previous cycle
- s_wrdata  out  8  S write data
- s_wren  out  1  S write enable
- pt_addr  out  8  plaintext memory address
- pt_rddata  in  8  plaintext read data (1-cycle latency)
- ct_addr  out  8  ciphertext memory address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable

Behaviour:
- Message format: byte 0 holds length L (0..255); bytes 1..L hold the payload. The same format applies to PT and CT.
- Memory outputs are combinational from state. Outside the states listed below, every address, write-data and write-enable output is 0.
- Reset: state=IDLE; i, j, k, si, sj, L all 0; all wren=0 from the cycle after the reset edge; rdy=1.
- Reset mid-operation aborts the message. No further writes occur, and partially written CT bytes are left as they are.
- IDLE: rdy=1. On en=1: clear i, j, k (k<=1), then go to RD_LEN. en while busy is ignored; it is not queued.
- RD_LEN: pt_addr=0.
- WR_LEN: L<=pt_rddata; ct_addr=0, ct_wrdata=pt_rddata, ct_wren=1. If pt_rddata==0 go to IDLE, else go to RD_SI.
- RD_SI: s_addr=i+1; i<=i+1.
- RD_SJ: si<=s_rddata; j<=j+s_rddata; s_addr=j+s_rddata.
- WR_SJ: sj<=s_rddata; s_addr=j, s_wrdata=si, s_wren=1.
- WR_SI: s_addr=i, s_wrdata=sj, s_wren=1.
- RD_PAD: s_addr=si+sj; pt_addr=k.
- WR_CT: ct_addr=k, ct_wrdata=s_rddata^pt_rddata, ct_wren=1. If k==L go to IDLE, else k<=k+1 and go to RD_SI.
- All i/j/pad arithmetic is 8-bit, modulo 256; wrap-around is silent.
- k is compared to L before incrementing, so L=255 does not overflow k.
- Latency: the state machine occupies 2+5L cycles after the accepting edge; rdy reasserts 2+5L edges later. L=0 gives 2 cycles.
- There is exactly one write per cycle and never two memories written in the same cycle.

Optional Feature:
- Macro: PRGA_ENC_CONT_EN.
- Defined: i and j are not cleared on accept; they persist across messages, so consecutive messages form one continuous keystream. Only rst clears them.
- Undefined: i and j are cleared on every accept.
- S memory is never re-initialised by this block in either mode.

Decomposition:
- Shared package rc4_pkg holds:
  - state enum (IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SJ, WR_SI, RD_PAD, WR_CT)
  - BYTE_W=8
  - LEN_ADDR=0
- One natural sub-module, rc4_ks_step. It handles the S read/swap/pad-address sequencing for one byte, with start/done handshaking. It is reusable by the decrypt path.

Test Plan:
- Identity S (S[x]=x), PT={03,00,00,00}, pulse en -> CT={03,02,05,07}; S[2]=03, S[3]=05, S[5]=02; rdy low for 17 cycles.
- Identity S, PT={03,FF,10,AA} -> CT={03,FD,15,AD}.
- PT[0]=00 -> single CT write {addr 0, data 00}; no S writes; rdy back after 2 cycles.
- After test 1 (S left modified), PT={01,00}, without macro -> CT={01,03}; with PRGA_ENC_CONT_EN -> CT={01,0D}.
- Assert rst during byte 2 of a 3-byte message -> all wren low the next cycle, rdy=1, CT[3] unwritten; a fresh en restarts correctly.
- L=255 with random PT and S from a reference KSA -> all 255 bytes match the software RC4 model; rdy after 1277 cycles; en held high throughout accepts only at IDLE.
